seq_alu_mdu: RTL and testbench
==============================

Name: seq_alu_mdu

Overview:
- Parametrised successor to the datapath ALU.
- Registered ALU with the legacy 4-bit operation select, plus an iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake.
- Sits in the EX stage of the multi-cycle datapath; the control FSM issues start and waits for done.

Parameters:
- WIDTH, 32, operand/result width in bits (even, >=8).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  issue operation; sampled only when busy=0
- op  in  4  operation select (encoding below)
- a  in  WIDTH  operand A / dividend / multiplicand
- b  in  WIDTH  operand B / divisor / multiplier
- result  out  WIDTH  registered ALU result
- zero  out  1  result==0, registered with result
- overflow  out  1  signed overflow for ADD/SUB, else 0
- hi  out  WIDTH  HI register (MULT high half / remainder)
- lo  out  WIDTH  LO register (MULT low half / quotient)
- busy  out  1  multi-cycle op in progress
- done  out  1  one-cycle completion pulse
- div_by_zero  out  1  valid with done; set for DIV/DIVU with b==0
- illegal_op  out  1  valid with done; undefined op code

Behaviour:
- Reset: result, hi, lo = 0; zero = 1; overflow, busy, done, div_by_zero, illegal_op = 0; state=IDLE. Reset mid-operation aborts it; no done is issued.
- Op encoding:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 6 SUB, 7 SLT (signed), 8 SLTU, 12 NOR, 14 MFHI, 15 MFLO.
  - 9 MULT, 10 MULTU, 11 DIV, 13 DIVU.
  - 4, 5 illegal.
- FSM states: IDLE, CALC, FIX, DONE.
  - start is accepted in IDLE or DONE. start while busy=1 is ignored, with no side effects.
- Single-cycle ops (including illegal):
  - state -> DONE; result/zero/overflow/illegal_op update at the accept edge; done=1 the following cycle.
  - Latency 1 edge. Back-to-back starts give a done every cycle.
  - Illegal op: result=0, zero=1, illegal_op=1.
- MULT/MULTU/DIV/DIVU:
  - Accept edge: latch operands; signed ops take magnitudes and record result signs.
  - CALC: exactly WIDTH cycles. Multiply is shift-add, one bit per cycle. Divide is restoring, one quotient bit per cycle.
  - FIX: one cycle. Apply sign correction and write hi/lo.
  - DONE: done=1 for one cycle. busy=1 throughout CALC and FIX.
  - Latency: done is visible WIDTH+2 edges after the accept edge.
- Multi-cycle ops leave result/zero/overflow unchanged; hi/lo hold until the next MULT/DIV completes.
- Signed divide semantics:
  - quotient truncates toward zero; remainder takes the sign of the dividend.
  - most-negative / -1: lo = most-negative, hi = 0, no flag.
- Divide by zero: short-circuit to DONE after 1 edge. lo = all ones, hi = a, div_by_zero=1.
- overflow for ADD/SUB: operand signs match (ADD) or differ (SUB) and the result sign differs from A.
- MFHI/MFLO: result = hi/lo at the accept edge. An MFHI/MFLO accepted in the same cycle as a FIX cannot occur, because busy=1 during FIX.
- done, div_by_zero and illegal_op are 0 in every cycle other than the done cycle.

Optional Feature:
- Macro: SEQ_ALU_MDU_DIV_EN.
- Defined: DIV/DIVU are implemented as above.
- Undefined: the divider datapath is omitted. Ops 11 and 13 are treated as illegal (1-edge latency, illegal_op=1, result=0, hi/lo unchanged). MULT/MULTU are unaffected.

Decomposition:
- Shared package seq_alu_pkg holds:
  - op code localparams (OP_AND ... OP_MFLO), including the legacy 0/1/2/6/7/12 values so the existing ALU control decoder drives op unchanged;
  - FSM state enum;
  - is_multicycle(op) function.
- One sub-module, seq_alu_mdu_core:
  - holds the iterative multiply/divide datapath, CNT_W counter and sign fixup;
  - handshake via go/fin;
  - the top handles ALU ops, flags, handshake and hi/lo write.

Test Plan:
- ADD a=0x7FFFFFFF b=1 -> next cycle result=0x80000000, overflow=1, zero=0, done=1. SUB 5-5 -> result=0, zero=1, overflow=0.
- MULT a=-3 (0xFFFFFFFD) b=5 -> done exactly 34 edges after accept; hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. Then MFLO -> result=14 after 1 edge.
- DIV a=0x1234 b=0 -> done after 1 edge; lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1. Without SEQ_ALU_MDU_DIV_EN: illegal_op=1, hi/lo unchanged.
- Start MULT, then assert start with ADD on cycles 1..10 -> ADD ignored, result unchanged, single done at edge 34. Op=4 -> illegal_op=1, result=0.
- Start DIVU, assert rst at CALC cycle 10 -> next cycle all outputs at reset values, no done; a new MULT after reset completes normally.

Source files
------------

// File: rtl/seq_alu_mdu_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for seq_alu_mdu.
// Pure declarations: no latency. No flow control.
// No backpressure.
package seq_alu_pkg;

  // Legacy codes 0/1/2/6/7/12 are kept so the existing ALU control decoder drives op unchanged.
  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SLTU  = 4'd8;
  localparam logic [3:0] OP_MULT  = 4'd9;
  localparam logic [3:0] OP_MULTU = 4'd10;
  localparam logic [3:0] OP_DIV   = 4'd11;
  localparam logic [3:0] OP_NOR   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_MFHI  = 4'd14;
  localparam logic [3:0] OP_MFLO  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_md(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_alu_mdu_if.sv
// Issue/response bundle between the EX-stage control FSM (master) and seq_alu_mdu (slave).
// No latency of its own.
// Backpressure: master must hold off issuing while busy=1; starts during busy are dropped.
interface seq_alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             illegal_op;

  modport master (
    output start, op, a, b,
    input  result, zero, overflow, hi, lo, busy, done, div_by_zero, illegal_op
  );

  modport slave (
    input  start, op, a, b,
    output result, zero, overflow, hi, lo, busy, done, div_by_zero, illegal_op
  );
endinterface

// File: rtl/seq_alu_mdu_core.sv
// Iterative shift-add multiplier / restoring divider on magnitudes, with sign fixup (divider under SEQ_ALU_MDU_DIV_EN).
// Latency: fin is high in the last of WIDTH iteration cycles after go; hi_fix/lo_fix are valid the cycle after.
// Backpressure: none; go is only pulsed by the top when the unit is idle.
module seq_alu_mdu_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] hi_fix,
  output logic [WIDTH-1:0] lo_fix
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               active_q;
  logic               neg_lo_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] ld_acc;
  logic [WIDTH-1:0]   ld_opnd;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] mul_fix;

  assign a_neg = is_signed_md(op) & a[WIDTH-1];
  assign b_neg = is_signed_md(op) & b[WIDTH-1];
  assign mag_a = a_neg ? (~a + 1'b1) : a;
  assign mag_b = b_neg ? (~b + 1'b1) : b;

  // Multiply: acc = {partial high, multiplier shifting out LSB first}.
  assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {add_sum, acc_q[WIDTH-1:1]};
  assign mul_fix  = neg_lo_q ? (~acc_q + 1'b1) : acc_q;

`ifdef SEQ_ALU_MDU_DIV_EN
  logic               div_q;
  logic               neg_hi_q;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_step;

  // Divide: acc = {partial remainder, dividend shifting into quotient from the LSB}.
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign trial    = rem_sh - {1'b0, opnd_q};
  assign div_step = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
  assign step     = div_q ? div_step : mul_step;

  always_comb begin
    ld_acc  = {{WIDTH{1'b0}}, mag_b};
    ld_opnd = mag_a;
    if (is_div(op)) begin
      ld_acc  = {{WIDTH{1'b0}}, mag_a};
      ld_opnd = mag_b;
    end
  end

  // Quotient sign follows a^b, remainder sign follows the dividend.
  always_comb begin
    hi_fix = mul_fix[2*WIDTH-1:WIDTH];
    lo_fix = mul_fix[WIDTH-1:0];
    if (div_q) begin
      hi_fix = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
      lo_fix = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (go) begin
      div_q    <= is_div(op);
      neg_hi_q <= a_neg;
    end
  end
`else
  assign step    = mul_step;
  assign ld_acc  = {{WIDTH{1'b0}}, mag_b};
  assign ld_opnd = mag_a;
  assign hi_fix  = mul_fix[2*WIDTH-1:WIDTH];
  assign lo_fix  = mul_fix[WIDTH-1:0];
`endif

  assign fin = active_q && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      neg_lo_q <= 1'b0;
    end else if (go) begin
      acc_q    <= ld_acc;
      opnd_q   <= ld_opnd;
      cnt_q    <= '0;
      active_q <= 1'b1;
      neg_lo_q <= a_neg ^ b_neg;
    end else if (active_q) begin
      acc_q <= step;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == LAST) active_q <= 1'b0;
    end
  end
endmodule

// File: rtl/seq_alu_mdu.sv
// EX-stage registered ALU plus iterative MULT/DIV unit with HI/LO; divider present only with SEQ_ALU_MDU_DIV_EN.
// Latency: ALU ops / illegal / divide-by-zero done after 1 edge; MULT/DIV done WIDTH+2 edges after accept.
// Backpressure: busy=1 during CALC/FIX; start is only accepted in IDLE or DONE, otherwise dropped.
module seq_alu_mdu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  seq_alu_mdu_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, hi_q, lo_q;
  logic             zero_q, ovf_q, dbz_q, ill_q;

  logic             accept, mc_op, dz, go, fin;
  logic [WIDTH-1:0] hi_fix, lo_fix;
  logic [WIDTH-1:0] sum, dif, alu_res;
  logic             alu_ovf, alu_ill;

`ifdef SEQ_ALU_MDU_DIV_EN
  assign mc_op = is_multicycle(bus.op);
`else
  assign mc_op = is_multicycle(bus.op) && !is_div(bus.op);
`endif
  assign dz     = mc_op && is_div(bus.op) && (bus.b == '0);
  assign accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  assign sum = bus.a + bus.b;
  assign dif = bus.a - bus.b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.op)
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          if (mc_op && !dz) begin
            state_d = ST_CALC;
            go      = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_CALC: if (fin) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Multi-cycle ops never touch result/zero/overflow; hi/lo only change on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      if (accept) begin
        dbz_q <= 1'b0;
        ill_q <= 1'b0;
        if (!mc_op) begin
          result_q <= alu_res;
          zero_q   <= (alu_res == '0);
          ovf_q    <= alu_ovf;
          ill_q    <= alu_ill;
        end else if (dz) begin
          hi_q  <= bus.a;
          lo_q  <= '1;
          dbz_q <= 1'b1;
        end
      end
      if (state_q == ST_FIX) begin
        hi_q <= hi_fix;
        lo_q <= lo_fix;
      end
    end
  end

  seq_alu_mdu_core #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .op     (bus.op),
    .a      (bus.a),
    .b      (bus.b),
    .fin    (fin),
    .hi_fix (hi_fix),
    .lo_fix (lo_fix)
  );

  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.overflow    = ovf_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.div_by_zero = dbz_q & (state_q == ST_DONE);
  assign bus.illegal_op  = ill_q & (state_q == ST_DONE);
endmodule

// File: tb/tb_seq_alu_mdu.sv
// Bench for seq_alu_mdu: directed vector table, multi-cycle corner sequences, randomized ops vs a 64-bit arithmetic model.
// Expectations follow SEQ_ALU_MDU_DIV_EN when it is defined for the build.
module tb_seq_alu_mdu;
  import seq_alu_pkg::*;

  localparam int W  = 32;
  localparam int LM = W + 2;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res, hi, lo;
    logic        zero, ovf, dbz, ill;
    int          lat;
  } vec_t;

  logic clk, rst;
  seq_alu_mdu_if #(.WIDTH(W)) bus ();

  seq_alu_mdu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_res, m_hi, m_lo;
  logic        m_zero, m_ovf;

  task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, b, res,
                              input logic zero, ovf, input logic [31:0] hi, lo,
                              input logic dbz, ill, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.zero = zero; v.ovf = ovf;
    v.hi = hi; v.lo = lo; v.dbz = dbz; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  // Reference model: plain 64-bit arithmetic on the architectural state.
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] a, b);
    vec_t        e;
    longint      sa, sb, s;
    logic [63:0] p, q, rm, ua, ub;
    logic [31:0] r;
    logic        single, ovf;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    e = mk(op, a, b, m_res, m_zero, m_ovf, m_hi, m_lo, 1'b0, 1'b0, 1);
    single = 1'b1; r = '0; ovf = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_ADD:  begin s = sa + sb; r = s[31:0]; ovf = !((s[63:31] == '0) || (s[63:31] == '1)); end
      OP_SUB:  begin s = sa - sb; r = s[31:0]; ovf = !((s[63:31] == '0) || (s[63:31] == '1)); end
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      OP_MFHI: r = m_hi;
      OP_MFLO: r = m_lo;
      OP_MULT:  begin single = 1'b0; p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = LM; end
      OP_MULTU: begin single = 1'b0; p = ua * ub; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = LM; end
`ifdef SEQ_ALU_MDU_DIV_EN
      OP_DIV, OP_DIVU: begin
        single = 1'b0;
        if (b == 0) begin
          e.hi = a; e.lo = '1; e.dbz = 1'b1;
        end else begin
          if (op == OP_DIV) begin q = sa / sb; rm = sa % sb; end
          else begin q = ua / ub; rm = ua % ub; end
          e.lo = q[31:0]; e.hi = rm[31:0]; e.lat = LM;
        end
      end
`endif
      default: e.ill = 1'b1;
    endcase
    if (single) begin e.res = r; e.zero = (r == 0); e.ovf = ovf; end
    return e;
  endfunction

  task automatic issue(input vec_t e, input string tag);
    int edges;
    edges = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = e.op; bus.a = e.a; bus.b = e.b;
    @(posedge clk); edges = 1;
    @(negedge clk); bus.start = 1'b0;
    while (!bus.done && edges < W + 8) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    chk({tag, ".done"}, bus.done, 1);
    chk({tag, ".latency"}, edges, e.lat);
    chk({tag, ".result"}, bus.result, e.res);
    chk({tag, ".zero"}, bus.zero, e.zero);
    chk({tag, ".overflow"}, bus.overflow, e.ovf);
    chk({tag, ".hi"}, bus.hi, e.hi);
    chk({tag, ".lo"}, bus.lo, e.lo);
    chk({tag, ".div_by_zero"}, bus.div_by_zero, e.dbz);
    chk({tag, ".illegal_op"}, bus.illegal_op, e.ill);
    m_res = e.res; m_zero = e.zero; m_ovf = e.ovf; m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".result"}, bus.result, 0);
    chk({tag, ".zero"}, bus.zero, 1);
    chk({tag, ".overflow"}, bus.overflow, 0);
    chk({tag, ".hi"}, bus.hi, 0);
    chk({tag, ".lo"}, bus.lo, 0);
    chk({tag, ".busy"}, bus.busy, 0);
    chk({tag, ".done"}, bus.done, 0);
    chk({tag, ".div_by_zero"}, bus.div_by_zero, 0);
    chk({tag, ".illegal_op"}, bus.illegal_op, 0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t        tbl[$];
    vec_t        e;
    logic [31:0] hv, lv;
    int          first, ndone;
    logic [3:0]  op_r;

    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    m_res = '0; m_zero = 1'b1; m_ovf = 1'b0; m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Directed table; expected values are hand-derived and depend on row order.
    tbl.push_back(mk(OP_ADD,   32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(OP_SUB,   32'd5, 32'd5, 32'd0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(OP_MULT,  32'hFFFFFFFD, 32'd5, 32'd0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 0, LM));
    tbl.push_back(mk(OP_MULTU, 32'hFFFFFFFD, 32'd5, 32'd0, 1, 0, 32'h4, 32'hFFFFFFF1, 0, 0, LM));
`ifdef SEQ_ALU_MDU_DIV_EN
    tbl.push_back(mk(OP_DIV,  32'hFFFFFFF9, 32'd2, 32'd0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, LM));
    tbl.push_back(mk(OP_DIVU, 32'd100, 32'd7, 32'd0, 1, 0, 32'd2, 32'd14, 0, 0, LM));
    tbl.push_back(mk(OP_MFLO, 32'd0, 32'd0, 32'd14, 0, 0, 32'd2, 32'd14, 0, 0, 1));
    tbl.push_back(mk(OP_DIV,  32'h1234, 32'd0, 32'd14, 0, 0, 32'h1234, 32'hFFFFFFFF, 1, 0, 1));
    tbl.push_back(mk(4'd4,    32'd3, 32'd4, 32'd0, 1, 0, 32'h1234, 32'hFFFFFFFF, 0, 1, 1));
    tbl.push_back(mk(OP_MFHI, 32'd0, 32'd0, 32'h1234, 0, 0, 32'h1234, 32'hFFFFFFFF, 0, 0, 1));
    hv = 32'h1234; lv = 32'hFFFFFFFF;
`else
    tbl.push_back(mk(OP_DIV,  32'hFFFFFFF9, 32'd2, 32'd0, 1, 0, 32'h4, 32'hFFFFFFF1, 0, 1, 1));
    tbl.push_back(mk(OP_DIVU, 32'd100, 32'd7, 32'd0, 1, 0, 32'h4, 32'hFFFFFFF1, 0, 1, 1));
    tbl.push_back(mk(OP_MFLO, 32'd0, 32'd0, 32'hFFFFFFF1, 0, 0, 32'h4, 32'hFFFFFFF1, 0, 0, 1));
    tbl.push_back(mk(OP_DIV,  32'h1234, 32'd0, 32'd0, 1, 0, 32'h4, 32'hFFFFFFF1, 0, 1, 1));
    tbl.push_back(mk(4'd4,    32'd3, 32'd4, 32'd0, 1, 0, 32'h4, 32'hFFFFFFF1, 0, 1, 1));
    tbl.push_back(mk(OP_MFHI, 32'd0, 32'd0, 32'h4, 0, 0, 32'h4, 32'hFFFFFFF1, 0, 0, 1));
    hv = 32'h4; lv = 32'hFFFFFFF1;
`endif
    tbl.push_back(mk(4'd5,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1, 0, hv, lv, 0, 1, 1));
    tbl.push_back(mk(OP_AND,  32'hF0F0, 32'hFF00, 32'hF000, 0, 0, hv, lv, 0, 0, 1));
    tbl.push_back(mk(OP_OR,   32'h0F, 32'hF0, 32'hFF, 0, 0, hv, lv, 0, 0, 1));
    tbl.push_back(mk(OP_XOR,  32'hFF, 32'h0F, 32'hF0, 0, 0, hv, lv, 0, 0, 1));
    tbl.push_back(mk(OP_NOR,  32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, hv, lv, 0, 0, 1));
    tbl.push_back(mk(OP_SLT,  32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, hv, lv, 0, 0, 1));
    tbl.push_back(mk(OP_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0, hv, lv, 0, 0, 1));
    tbl.push_back(mk(OP_SUB,  32'h80000000, 32'd1, 32'h7FFFFFFF, 0, 1, hv, lv, 0, 0, 1));
    tbl.push_back(mk(OP_ADD,  32'hFFFFFFFF, 32'd1, 32'd0, 1, 0, hv, lv, 0, 0, 1));
    tbl.push_back(mk(OP_SUB,  32'd0, 32'h80000000, 32'h80000000, 0, 1, hv, lv, 0, 0, 1));
    tbl.push_back(mk(OP_MULT, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1, 32'd0, 32'h80000000, 0, 0, LM));
`ifdef SEQ_ALU_MDU_DIV_EN
    tbl.push_back(mk(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1, 32'd0, 32'h80000000, 0, 0, LM));
    tbl.push_back(mk(OP_DIV,  32'd7, 32'hFFFFFFFE, 32'h80000000, 0, 1, 32'd1, 32'hFFFFFFFD, 0, 0, LM));
    tbl.push_back(mk(OP_MFLO, 32'd0, 32'd0, 32'hFFFFFFFD, 0, 0, 32'd1, 32'hFFFFFFFD, 0, 0, 1));
`else
    tbl.push_back(mk(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 0, 32'd0, 32'h80000000, 0, 1, 1));
    tbl.push_back(mk(OP_DIVU, 32'd7, 32'hFFFFFFFE, 32'd0, 1, 0, 32'd0, 32'h80000000, 0, 1, 1));
    tbl.push_back(mk(OP_MFLO, 32'd0, 32'd0, 32'h80000000, 0, 0, 32'd0, 32'h80000000, 0, 0, 1));
`endif
    for (int i = 0; i < tbl.size(); i++) issue(tbl[i], $sformatf("row%0d", i));

    // Start held with ADD during the first 10 CALC cycles: must be ignored, one done only.
    e = model(OP_MULT, 32'h12345678, 32'h9ABCDEF0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = e.a; bus.b = e.b;
    @(posedge clk);
    @(negedge clk);
    bus.op = OP_ADD; bus.a = 32'd1; bus.b = 32'd1;
    first = 0; ndone = 0;
    for (int k = 1; k <= W + 6; k++) begin
      if (bus.done) begin ndone++; if (first == 0) first = k; end
      if (k == 11) bus.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    chk("busy_ign.done_edge", first, LM);
    chk("busy_ign.done_count", ndone, 1);
    chk("busy_ign.result", bus.result, m_res);
    chk("busy_ign.overflow", bus.overflow, m_ovf);
    chk("busy_ign.hi", bus.hi, e.hi);
    chk("busy_ign.lo", bus.lo, e.lo);
    m_hi = e.hi; m_lo = e.lo;

    // Back-to-back single-cycle ops: done every cycle.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: e = model(OP_ADD, 32'd3, 32'd4);
        1: e = model(OP_SUB, 32'd10, 32'd3);
        2: e = model(OP_XOR, 32'hA5A5A5A5, 32'hFFFF0000);
        default: e = model(OP_MFHI, 32'd0, 32'd0);
      endcase
      bus.start = 1'b1; bus.op = e.op; bus.a = e.a; bus.b = e.b;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b%0d.done", i), bus.done, 1);
      chk($sformatf("b2b%0d.result", i), bus.result, e.res);
      m_res = e.res; m_zero = e.zero; m_ovf = e.ovf;
    end
    bus.start = 1'b0;

    // Reset during CALC cycle 10 aborts with no done.
`ifdef SEQ_ALU_MDU_DIV_EN
    op_r = OP_DIVU;
`else
    op_r = OP_MULTU;
`endif
    @(negedge clk);
    bus.start = 1'b1; bus.op = op_r; bus.a = 32'd1000; bus.b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    chk("abort.busy_before", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("abort");
    ndone = 0;
    repeat (W + 4) begin
      @(posedge clk); @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort.no_done", ndone, 0);
    m_res = '0; m_zero = 1'b1; m_ovf = 1'b0; m_hi = '0; m_lo = '0;
    issue(model(OP_MULT, 32'hFFFFFF00, 32'h00000123), "post_reset_mult");

    // Randomized ops against the model.
    for (int i = 0; i < 40; i++) begin
      op_r = 4'($urandom_range(0, 15));
      e = model(op_r, pick_operand(), pick_operand());
      issue(e, $sformatf("rnd%0d_op%0d", i, op_r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
